// File: rtl/dkongjr_wav_sched.sv
// Sample table, request scheduler and wave-ROM slot arbiter for the 8-channel DKJ player bank.
// Optional: define DKJ_WAV_RR_EN for round-robin channel selection (default is fixed priority, ch0 first).
module dkongjr_wav_sched #(
  parameter int NCH       = 8,
  parameter int TRIG_HOLD = 2
) (
  input  logic              I_CLK,
  input  logic              I_RSTn,
  input  logic [NCH-1:0]    I_REQ,
  input  logic [NCH-1:0]    I_STOP,
  input  logic              I_CFG_WE,
  input  logic [2:0]        I_CFG_CHAN,
  input  logic [1:0]        I_CFG_SEL,
  input  logic [15:0]       I_CFG_DATA,
  input  logic [16*NCH-1:0] I_CH_ADDR,
  input  logic [15:0]       I_ROM_DATA,
  output logic [3:0]        O_H_CNT,
  output logic [15:0]       O_ROM_ADDR,
  output logic [15:0]       O_ROM_DATA,
  output logic [NCH-1:0]    O_DMA_TRIG,
  output logic [NCH-1:0]    O_DMA_STOP,
  output logic [15:0]       O_START_ADDR,
  output logic [16*NCH-1:0] O_LEN,
  output logic [12*NCH-1:0] O_DIV,
  output logic              O_BUSY
);

  typedef enum logic [1:0] {IDLE, SEL, FIRE, HOLD} state_t;

  state_t         state_reg, state_next;
  logic [3:0]     h_cnt_reg;
  logic [15:0]    rom_addr_reg;
  logic [15:0]    start_tab [NCH];
  logic [15:0]    len_tab [NCH];
  logic [11:0]    div_tab [NCH];
  logic [NCH-1:0] req_reg, req_prev_reg, stop_reg;
  logic [NCH-1:0] pending_reg, pending_next;
  logic [NCH-1:0] trig_reg, trig_next;
  logic [15:0]    start_reg, start_next;
  logic [1:0]     hold_cnt_reg, hold_cnt_next;
  logic [NCH-1:0] len_nz, rise, clr;
  logic [2:0]     base, pick, slot_next;
  logic           pick_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign len_nz[gi]          = |len_tab[gi];
      assign O_LEN[16*gi +: 16]  = len_tab[gi];
      assign O_DIV[12*gi +: 12]  = div_tab[gi];
    end
  endgenerate

`ifdef DKJ_WAV_RR_EN
  logic [2:0] last_reg, last_next;
  assign base = last_reg + 3'd1;
`else
  assign base = 3'd0;
`endif

  // Scan backwards so the first pending channel in search order is the one kept.
  always_comb begin
    logic [2:0] idx;
    pick    = 3'd0;
    pick_ok = 1'b0;
    idx     = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = base + 3'(i);
      if (pending_reg[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  assign rise         = req_reg & ~req_prev_reg;
  // Stop beats a new request, a new request beats the scheduler's clear.
  assign pending_next = ~stop_reg & ((rise & len_nz) | (pending_reg & ~clr));
  assign slot_next    = h_cnt_reg[3:1] + 3'd1;

  always_comb begin
    state_next    = state_reg;
    trig_next     = trig_reg;
    start_next    = start_reg;
    hold_cnt_next = hold_cnt_reg;
    clr           = '0;
`ifdef DKJ_WAV_RR_EN
    last_next     = last_reg;
`endif
    case (state_reg)
      IDLE: if (|pending_reg) state_next = SEL;
      SEL: begin
        if (pick_ok) begin
          clr[pick]       = 1'b1;
          start_next      = start_tab[pick];
          trig_next       = '0;
          trig_next[pick] = 1'b1;
          hold_cnt_next   = 2'd1;
`ifdef DKJ_WAV_RR_EN
          last_next       = pick;
`endif
          state_next      = FIRE;
        end else begin
          state_next = IDLE;
        end
      end
      FIRE, HOLD: begin
        // hold_cnt_reg counts trigger-high cycles already delivered
        if (hold_cnt_reg < 2'(TRIG_HOLD)) begin
          hold_cnt_next = hold_cnt_reg + 2'd1;
        end else begin
          trig_next = '0;
          if (state_reg == HOLD) state_next = IDLE;
        end
        if (state_reg == FIRE) state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_reg    <= IDLE;
      h_cnt_reg    <= '0;
      rom_addr_reg <= '0;
      req_reg      <= '0;
      req_prev_reg <= '0;
      stop_reg     <= '0;
      pending_reg  <= '0;
      trig_reg     <= '0;
      start_reg    <= '0;
      hold_cnt_reg <= '0;
`ifdef DKJ_WAV_RR_EN
      last_reg     <= 3'd7;
`endif
      for (int i = 0; i < NCH; i++) begin
        start_tab[i] <= '0;
        len_tab[i]   <= '0;
        div_tab[i]   <= '0;
      end
    end else begin
      state_reg    <= state_next;
      h_cnt_reg    <= h_cnt_reg + 4'd1;
      if (h_cnt_reg[0]) rom_addr_reg <= I_CH_ADDR[{slot_next, 4'b0000} +: 16];
      req_reg      <= I_REQ;
      req_prev_reg <= req_reg;
      stop_reg     <= I_STOP;
      pending_reg  <= pending_next;
      trig_reg     <= trig_next;
      start_reg    <= start_next;
      hold_cnt_reg <= hold_cnt_next;
`ifdef DKJ_WAV_RR_EN
      last_reg     <= last_next;
`endif
      if (I_CFG_WE) begin
        case (I_CFG_SEL)
          2'd0:    start_tab[I_CFG_CHAN] <= I_CFG_DATA;
          2'd1:    len_tab[I_CFG_CHAN]   <= I_CFG_DATA;
          2'd2:    div_tab[I_CFG_CHAN]   <= I_CFG_DATA[11:0];
          default: ;
        endcase
      end
    end
  end

  assign O_H_CNT      = h_cnt_reg;
  assign O_ROM_ADDR   = rom_addr_reg;
  assign O_ROM_DATA   = I_ROM_DATA;
  assign O_DMA_TRIG   = trig_reg;
  assign O_DMA_STOP   = stop_reg;
  assign O_START_ADDR = start_reg;
  assign O_BUSY       = (state_reg != IDLE) || (|pending_reg);

endmodule

// File: tb/tb_dkongjr_wav_sched.sv
// Bench for dkongjr_wav_sched: table vectors, directed corner sequences and random traffic
// checked every cycle against a timeline model of the scheduler.
module tb_dkongjr_wav_sched;
  localparam int TH = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   req, stop;
  logic         cfg_we;
  logic [2:0]   cfg_chan;
  logic [1:0]   cfg_sel;
  logic [15:0]  cfg_data;
  logic [127:0] ch_addr;
  logic [15:0]  rom_data;
  logic [3:0]   h_cnt;
  logic [15:0]  rom_addr, rom_q, start_addr;
  logic [7:0]   trig, dstop;
  logic [127:0] len_o;
  logic [95:0]  div_o;
  logic         busy;

  always #5 clk = ~clk;

  dkongjr_wav_sched #(.NCH(8), .TRIG_HOLD(TH)) dut (
    .I_CLK(clk), .I_RSTn(rst_n), .I_REQ(req), .I_STOP(stop),
    .I_CFG_WE(cfg_we), .I_CFG_CHAN(cfg_chan), .I_CFG_SEL(cfg_sel), .I_CFG_DATA(cfg_data),
    .I_CH_ADDR(ch_addr), .I_ROM_DATA(rom_data),
    .O_H_CNT(h_cnt), .O_ROM_ADDR(rom_addr), .O_ROM_DATA(rom_q), .O_DMA_TRIG(trig),
    .O_DMA_STOP(dstop), .O_START_ADDR(start_addr), .O_LEN(len_o), .O_DIV(div_o), .O_BUSY(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edge counter plus the edges at which the scheduler picks / frees up.
  int          n = 0;
  int          idle_from = 0, pick_at = -1, trig_from = -10, trig_to = -11, trig_ch = 0;
  logic [7:0]  m_pend, m_req1, m_req2, m_stop1;
  logic [15:0] m_start [8];
  logic [15:0] m_len [8];
  logic [11:0] m_div [8];
  logic [3:0]  m_h;
  logic [15:0] m_rom, m_start_out;
  logic [2:0]  m_last;
  logic [7:0]  trig_prev;
  int          rises [8];
  int          obs_ch[$];
  int          obs_n[$];

  typedef struct {
    logic [2:0]  chan;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] exp_len;
    logic [11:0] exp_div;
  } cfg_vec_t;
  cfg_vec_t vecs [14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_req1 = '0; m_req2 = '0; m_stop1 = '0;
    m_h = '0; m_rom = '0; m_start_out = '0; m_last = 3'd7; trig_prev = '0;
    for (int i = 0; i < 8; i++) begin
      m_start[i] = '0; m_len[i] = '0; m_div[i] = '0;
    end
    idle_from = n; pick_at = -1; trig_from = -10; trig_to = -11;
  endtask

  task automatic model_edge();
    logic [7:0] rise, clr, pnew;
    int c, base, k;
    rise = m_req1 & ~m_req2;
    clr  = '0;
    pnew = '0;
    c    = -1;
    n++;
    if (pick_at == n) begin
`ifdef DKJ_WAV_RR_EN
      base = (int'(m_last) + 1) % 8;
`else
      base = 0;
`endif
      for (int i = 0; i < 8; i++) begin
        k = (base + i) % 8;
        if (c < 0 && m_pend[k]) c = k;
      end
      if (c >= 0) begin
        clr[c]      = 1'b1;
        m_start_out = m_start[c];
        trig_ch     = c;
        trig_from   = n;
        trig_to     = n + TH - 1;
        idle_from   = n + ((TH > 2) ? TH : 2);
        m_last      = 3'(c);
      end else begin
        idle_from = n;
      end
      pick_at = -1;
    end else if (pick_at < 0 && n - 1 >= idle_from && m_pend != 0) begin
      pick_at = n + 1;
    end
    for (int j = 0; j < 8; j++)
      pnew[j] = m_stop1[j] ? 1'b0 : (rise[j] && m_len[j] != 0) ? 1'b1 : clr[j] ? 1'b0 : m_pend[j];
    m_pend  = pnew;
    m_req2  = m_req1;
    m_req1  = req;
    m_stop1 = stop;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: m_start[cfg_chan] = cfg_data;
        2'd1: m_len[cfg_chan]   = cfg_data;
        2'd2: m_div[cfg_chan]   = cfg_data[11:0];
        default: ;
      endcase
    end
    m_h = m_h + 4'd1;
    if (!m_h[0]) begin
      k = int'(m_h[3:1]);
      m_rom = ch_addr[16*k +: 16];
    end
  endtask

  task automatic check_all();
    logic [7:0]   exp_trig;
    logic [127:0] el;
    logic [95:0]  ed;
    logic         exp_busy;
    exp_trig = (n >= trig_from && n <= trig_to) ? (8'b1 << trig_ch) : 8'h00;
    exp_busy = (pick_at >= 0) || (n < idle_from) || (m_pend != 0);
    for (int k = 0; k < 8; k++) begin
      el[16*k +: 16] = m_len[k];
      ed[12*k +: 12] = m_div[k];
    end
    check("h_cnt", h_cnt, m_h);
    check("rom_addr", rom_addr, m_rom);
    check("rom_data", rom_q, rom_data);
    check("dma_trig", trig, exp_trig);
    check("dma_stop", dstop, m_stop1);
    check("busy", busy, exp_busy);
    check("len", len_o, el);
    check("div", div_o, ed);
    if (exp_trig != 0) check("start_addr", start_addr, m_start_out);
    for (int k = 0; k < 8; k++) begin
      if (trig[k] && !trig_prev[k]) begin
        rises[k]++;
        obs_ch.push_back(k);
        obs_n.push_back(n);
        $display("issue ch%0d start %04h at edge %0d", k, start_addr, n);
      end
    end
    trig_prev = trig;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    logic found;
    int   first_ch, second_ch;
    rst_n = 1'b0; req = '0; stop = '0; cfg_we = 1'b0; cfg_chan = '0; cfg_sel = '0;
    cfg_data = '0; ch_addr = '0; rom_data = '0;
    model_reset();
    for (int k = 0; k < 8; k++) rises[k] = 0;

    vecs[0]  = '{3'd2, 2'd1, 16'h0100, 16'h0100, 12'h000};
    vecs[1]  = '{3'd2, 2'd2, 16'h012C, 16'h0100, 12'h12C};
    vecs[2]  = '{3'd2, 2'd2, 16'hF12C, 16'h0100, 12'h12C};
    vecs[3]  = '{3'd2, 2'd3, 16'hFFFF, 16'h0100, 12'h12C};
    vecs[4]  = '{3'd2, 2'd0, 16'h0400, 16'h0100, 12'h12C};
    vecs[5]  = '{3'd0, 2'd1, 16'h0010, 16'h0010, 12'h000};
    vecs[6]  = '{3'd0, 2'd0, 16'h1000, 16'h0010, 12'h000};
    vecs[7]  = '{3'd7, 2'd1, 16'h0020, 16'h0020, 12'h000};
    vecs[8]  = '{3'd7, 2'd0, 16'h7000, 16'h0020, 12'h000};
    vecs[9]  = '{3'd5, 2'd1, 16'h0008, 16'h0008, 12'h000};
    vecs[10] = '{3'd4, 2'd1, 16'h0008, 16'h0008, 12'h000};
    vecs[11] = '{3'd1, 2'd1, 16'h0000, 16'h0000, 12'h000};
    vecs[12] = '{3'd3, 2'd2, 16'h0FFF, 16'h0000, 12'hFFF};
    vecs[13] = '{3'd6, 2'd2, 16'h1005, 16'h0000, 12'h005};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_h_cnt", h_cnt, 4'h0);
    check("rst_rom_addr", rom_addr, 16'h0);
    check("rst_trig", trig, 8'h00);
    check("rst_stop", dstop, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_start", start_addr, 16'h0);
    check("rst_len", len_o, 128'h0);
    check("rst_div", div_o, 96'h0);
    #3 rst_n = 1'b1;
    model_reset();

    // Table vectors
    for (int v = 0; v < 14; v++) begin
      cfg_we = 1'b1; cfg_chan = vecs[v].chan; cfg_sel = vecs[v].sel; cfg_data = vecs[v].data;
      tick();
      cfg_we = 1'b0;
      $display("cfg ch%0d sel%0d data %04h", vecs[v].chan, vecs[v].sel, vecs[v].data);
      check("cfg_len", len_o[16*vecs[v].chan +: 16], vecs[v].exp_len);
      check("cfg_div", div_o[12*vecs[v].chan +: 12], vecs[v].exp_div);
    end

    // Slot counter and ROM address mux
    for (int k = 0; k < 8; k++) ch_addr[16*k +: 16] = 16'hA000 + 16'(k * 16'h0111);
    ch_addr[16*3 +: 16] = 16'h1234;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (h_cnt == 4'd0); end
    check("wait_slot0", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (h_cnt == 4'd7); end
    check("wait_slot7", found, 1'b1);
    check("rom_slot3", rom_addr, 16'h1234);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (h_cnt == 4'd15); end
    check("wait_slot15", found, 1'b1);
    tick();
    check("h_wrap", h_cnt, 4'd0);

    // Single trigger on ch2: rises on the 4th edge after the request edge, high for TH cycles
    req = 8'h04;
    run(3);
    check("trig_early", trig, 8'h00);
    tick();
    check("trig_latency", trig, 8'h04);
    check("trig_start", start_addr, 16'h0400);
    tick();
    check("trig_hold", trig, 8'h04);
    tick();
    check("trig_drop", trig, 8'h00);
    req = 8'h00;
    run(6);

    // Simultaneous requests on ch0 and ch7
    obs_ch.delete(); obs_n.delete();
    req = 8'h81;
    run(24);
`ifdef DKJ_WAV_RR_EN
    first_ch = 7; second_ch = 0;
`else
    first_ch = 0; second_ch = 7;
`endif
    check("simul_count", obs_ch.size(), 2);
    if (obs_ch.size() == 2) begin
      check("simul_first", obs_ch[0], first_ch);
      check("simul_second", obs_ch[1], second_ch);
      check("simul_gap_ok", (obs_n[1] - obs_n[0]) >= TH + 2, 1'b1);
    end
    check("simul_busy_done", busy, 1'b0);
    req = 8'h00;
    run(4);

    // Retrigger ch5: two request edges two cycles apart give two trigger edges
    rises[5] = 0;
    req = 8'h20; tick();
    req = 8'h00; tick();
    req = 8'h20;
    run(20);
    check("retrig_edges", rises[5], 2);
    req = 8'h00;
    run(4);

    // Zero-length channel never triggers
    rises[1] = 0;
    req = 8'h02;
    run(10);
    check("len0_no_trig", rises[1], 0);
    check("len0_idle", busy, 1'b0);
    req = 8'h00;
    run(2);

    // Stop in the same cycle as the request edge
    rises[4] = 0;
    req = 8'h10; stop = 8'h10;
    tick();
    check("stop_out", dstop[4], 1'b1);
    stop = 8'h00;
    run(10);
    check("stop_no_trig", rises[4], 0);
    req = 8'h00;
    run(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req = req ^ (8'h01 << $urandom_range(7));
      stop = ($urandom_range(31) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
      cfg_we = ($urandom_range(7) == 0);
      cfg_chan = 3'($urandom_range(7));
      cfg_sel = 2'($urandom_range(3));
      cfg_data = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
      ch_addr = {$urandom, $urandom, $urandom, $urandom};
      rom_data = 16'($urandom);
      tick();
    end
    req = '0; stop = '0; cfg_we = 1'b0;
    run(50);

    // Asynchronous reset while ch0's trigger is in HOLD
    cfg_we = 1'b1; cfg_chan = 3'd0; cfg_sel = 2'd1; cfg_data = 16'h0010;
    tick();
    cfg_we = 1'b0;
    req = 8'h01;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = trig[0]; end
    check("wait_ch0_trig", found, 1'b1);
    tick();
    check("trig_in_hold", trig, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trig", trig, 8'h00);
    check("arst_h_cnt", h_cnt, 4'h0);
    check("arst_rom_addr", rom_addr, 16'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_len", len_o, 128'h0);
    req = '0;
    model_reset();
    #2 rst_n = 1'b1;
    run(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dkongjr_wav_sched.md
Name: dkongjr_wav_sched

Overview:
- Scheduler and wave-ROM arbiter for the 8-channel DKJ sample-player bank.
- Holds a per-channel sample table (start, length, divider) loaded by the sound CPU.
- Turns CPU sound requests into clean player trigger edges, one channel at a time.
- Time-slices the single wave ROM between the 8 players via the shared 4-bit slot counter.

Parameters:
- NCH, 8, channel count; fixed at 8, channel index 3 bits.
- TRIG_HOLD, 2, cycles O_DMA_TRIG[k] stays high per issue (1..3).

Ports:
- I_CLK  in  1  system clock.
- I_RSTn  in  1  reset.
- I_REQ  in  8  per-channel play request, level from sound latch; rising edge = request.
- I_STOP  in  8  per-channel stop request, level.
- I_CFG_WE  in  1  table write strobe.
- I_CFG_CHAN  in  3  table channel.
- I_CFG_SEL  in  2  table field: 0 start addr, 1 length, 2 divider (low 12 bits), 3 ignored.
- I_CFG_DATA  in  16  table write data.
- I_CH_ADDR  in  128  player k's current ROM address at bits [16k+15:16k].
- I_ROM_DATA  in  16  wave ROM read data, synchronous ROM, 1-cycle latency.
- O_H_CNT  out  4  free-running slot counter to all players.
- O_ROM_ADDR  out  16  registered ROM address.
- O_ROM_DATA  out  16  I_ROM_DATA passed through combinationally, broadcast to all players.
- O_DMA_TRIG  out  8  per-channel trigger.
- O_DMA_STOP  out  8  per-channel stop, registered.
- O_START_ADDR  out  16  shared start address; valid whenever any O_DMA_TRIG bit is high.
- O_LEN  out  128  per-channel length from table.
- O_DIV  out  96  per-channel divider from table.
- O_BUSY  out  1  high when scheduler is not IDLE or any request is pending.

Behaviour:
- Reset: I_RSTn, asynchronous, active-low; clock I_CLK. All outputs, table entries, pending flags, edge registers and FSM state go to 0 / IDLE.
- Slot counter: O_H_CNT increments by 1 every cycle and wraps 15 -> 0.
- ROM address: on the edge where O_H_CNT becomes {k,0}, O_ROM_ADDR <= I_CH_ADDR[k]. ROM data for channel k is therefore valid during O_H_CNT = {k,1}, which is the cycle in which player k latches it. During odd slots O_ROM_ADDR holds its value.
- Table write: when I_CFG_WE is high, the selected field is written at the next edge. O_LEN and O_DIV reflect the table directly (registered, 1-cycle write latency).
- Request capture:
  - I_REQ is registered once; rising edge on bit k sets pending[k].
  - pending[k] is ignored (never set) while length[k] == 0.
  - If set and clear hit pending[k] in the same cycle, set wins.
- Stop: O_DMA_STOP[k] <= I_STOP[k], 1-cycle latency. A high I_STOP[k] also clears pending[k], and stop beats a same-cycle request edge. If channel k is in SEL/FIRE/HOLD when stop arrives, the trigger still completes; the stop is effective in the player.
- FSM:
  - IDLE: any pending -> SEL.
  - SEL: choose channel c (fixed priority, lowest index first). O_START_ADDR <= start[c]; clear pending[c]; -> FIRE.
  - FIRE: O_DMA_TRIG[c] = 1; -> HOLD.
  - HOLD: keep O_DMA_TRIG[c] = 1 for TRIG_HOLD total cycles, then drive 0; -> IDLE.
- Only one O_DMA_TRIG bit is ever high. Every O_DMA_TRIG bit is low for at least 2 cycles between highs, so a retrigger of a playing channel always produces a fresh rising edge.
- O_START_ADDR is held stable from SEL through the end of HOLD. A table write to start[c] during FIRE/HOLD does not change O_START_ADDR.
- Reset mid-issue: the trigger drops immediately and all pending requests are lost.

Optional Feature:
- Macro DKJ_WAV_RR_EN.
- Defined: SEL uses round-robin. Search starts at (last issued channel + 1) mod 8; the last-issued pointer resets to 7.
- Undefined: fixed priority, channel 0 highest.

Test Plan:
- Slot/ROM mux: I_CH_ADDR[3] = 0x1234, others distinct -> O_ROM_ADDR = 0x1234 during O_H_CNT = 7; O_H_CNT wraps 15 -> 0.
- Single trigger: table ch2 = {0x0400, 0x0100, 12'd300}, I_REQ[2] 0->1 -> O_DMA_TRIG[2] high 2 cycles with O_START_ADDR = 0x0400, starting 4 cycles after the I_REQ edge; O_LEN[2] = 0x0100; O_DIV[2] = 300.
- Simultaneous: I_REQ = 8'h81 same cycle -> ch0 issued, then ch7; triggers separated by at least 2 low cycles; O_BUSY falls after the ch7 HOLD. With DKJ_WAV_RR_EN and last issued = 0 -> ch7 first.
- Retrigger: I_REQ[5] toggled twice while ch5 is playing -> two separate O_DMA_TRIG[5] rising edges.
- Length zero / stop: length[1] = 0, I_REQ[1] edge -> no trigger. I_STOP[4] high on the same cycle as the I_REQ[4] edge -> no trigger, O_DMA_STOP[4] = 1 one cycle later.
- Async reset asserted during HOLD -> O_DMA_TRIG = 0, O_H_CNT = 0, O_ROM_ADDR = 0 immediately, with no clock edge.
